mole_game_fsm: RTL and testbench

MOLE_GAME_FSM -- requirements
Module: mole_game_fsm

---
 rtl/mole_game_fsm_if.sv | 28 ++
 rtl/mole_game_fsm.sv | 139 +++++++++++++
 tb/tb_mole_game_fsm.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mole_game_fsm_if.sv
// Signal bundle between the whack-a-mole control FSM and its board/timer side.
// master drives switches and remaining time; slave (the FSM) drives display and score.
interface mole_game_fsm_if;
    logic [15:0] sw;
    logic [7:0]  time_left;
    logic [15:0] LED;
    logic [7:0]  score_count;
    logic        hit_pulse;
    logic        game_over;

    modport master (
        output sw,
        output time_left,
        input  LED,
        input  score_count,
        input  hit_pulse,
        input  game_over
    );

    modport slave (
        input  sw,
        input  time_left,
        output LED,
        output score_count,
        output hit_pulse,
        output game_over
    );
endinterface

// File: rtl/mole_game_fsm.sv
// Whack-a-mole game controller: lights one pseudo-random LED (the mole),
// scores a hit when the matching switch toggles, flashes all LEDs on a hit,
// and stops in OVER once the game timer reaches zero.
module mole_game_fsm #(
    parameter int unsigned MOLE_CYCLES = 100_000_000,
    parameter int unsigned GAP_CYCLES  = 25_000_000,
    parameter int unsigned HIT_CYCLES  = 10_000_000,
    parameter int unsigned SCORE_MAX   = 99,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input logic            clk,
    input logic            reset,
    mole_game_fsm_if.slave bus
);
    localparam int unsigned CW = 27;
    localparam logic [CW-1:0] MOLE_LOAD = CW'(MOLE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] HIT_LOAD  = CW'(HIT_CYCLES - 1);
    localparam logic [7:0]    SCORE_LIM = 8'(SCORE_MAX);
    localparam logic [15:0]   LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {IDLE, GAP, SHOW, HIT, OVER} state_t;

    state_t        state, state_nx;
    logic [15:0]   sync1, sync2, prev, toggle;
    logic [15:0]   lfsr;
    logic [CW-1:0] cnt, cnt_nx;
    logic [3:0]    mole_idx, mole_nx, cand;
    logic [7:0]    score, score_nx;
    logic          hit_nx;
    logic [15:0]   led, led_nx;
    logic          over;

    assign toggle           = sync2 ^ prev;
    assign bus.LED          = led;
    assign bus.score_count  = score;
    assign bus.game_over    = over;

    // Two-flop synchronizer for the switches plus a history register for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= bus.sw;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Free-running Galois LFSR; advances every cycle regardless of state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= LFSR_SEED;
        else        lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    end

    // Candidate next mole, bumped by one so the same index never shows twice in a row.
    always_comb begin
        cand = lfsr[3:0];
        if (cand == mole_idx) cand = cand + 4'd1;
    end

    // Next-state, counter, score and registered-output values.
    always_comb begin
        state_nx = state;
        cnt_nx   = (cnt != '0) ? cnt - CW'(1) : cnt;
        mole_nx  = mole_idx;
        score_nx = score;
        hit_nx   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.time_left != '0) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LOAD;
                end
            end
            GAP: begin
                if (bus.time_left == '0) begin
                    state_nx = OVER;
                end else if (cnt == '0) begin
                    state_nx = SHOW;
                    cnt_nx   = MOLE_LOAD;
                    mole_nx  = cand;
                end
            end
            SHOW: begin
                if (bus.time_left == '0) begin
                    state_nx = OVER;
                end else if (toggle[mole_idx]) begin
                    state_nx = HIT;
                    cnt_nx   = HIT_LOAD;
                    hit_nx   = 1'b1;
                    if (score < SCORE_LIM) score_nx = score + 8'd1;
                end else if (toggle != '0 || cnt == '0) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LOAD;
                end
            end
            HIT: begin
                if (bus.time_left == '0) begin
                    state_nx = OVER;
                end else if (cnt == '0) begin
                    state_nx = GAP;
                    cnt_nx   = GAP_LOAD;
                end
            end
            OVER:    state_nx = OVER;
            default: state_nx = IDLE;
        endcase

        case (state_nx)
            SHOW:    led_nx = 16'h1 << mole_nx;
            HIT:     led_nx = '1;
            default: led_nx = '0;
        endcase
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            mole_idx      <= 4'hF;
            score         <= '0;
            led           <= '0;
            bus.hit_pulse <= 1'b0;
            over          <= 1'b0;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            mole_idx      <= mole_nx;
            score         <= score_nx;
            led           <= led_nx;
            bus.hit_pulse <= hit_nx;
            over          <= (state_nx == OVER);
        end
    end
endmodule

// File: tb/tb_mole_game_fsm.sv
// Directed bench for mole_game_fsm with short timing parameters.
module tb_mole_game_fsm;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    logic [15:0] m_lfsr, m_prev;
    logic [3:0]  exp_prev;
    logic [15:0] prev_led;

    mole_game_fsm_if bus ();

    mole_game_fsm #(
        .MOLE_CYCLES(8),
        .GAP_CYCLES (4),
        .HIT_CYCLES (2),
        .SCORE_MAX  (3),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference LFSR: m_prev holds the value the design sampled at the last edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] onehot(input logic [3:0] i);
        logic [15:0] v;
        v = 16'h1 << i;
        return v;
    endfunction

    // Wait for the next mole; check latency and the index predicted from the reference LFSR.
    task automatic wait_show(input int unsigned want);
        int unsigned n;
        logic [3:0] c;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.LED == '0 && n < want + 4);
        c = m_prev[3:0];
        if (c == exp_prev) c = c + 4'd1;
        exp_prev = c;
        chk("show_latency", n, want);
        chk("mole_led", bus.LED, onehot(c));
    endtask

    task automatic do_hit(input logic [7:0] old_score, input logic [7:0] new_score);
        bus.sw = bus.sw ^ onehot(exp_prev);
        tick();
        chk("hit_wait1_led", bus.LED, onehot(exp_prev));
        tick();
        chk("hit_wait2_score", bus.score_count, old_score);
        chk("hit_wait2_pulse", bus.hit_pulse, 1'b0);
        tick();
        chk("hit_score", bus.score_count, new_score);
        chk("hit_pulse", bus.hit_pulse, 1'b1);
        chk("hit_led_flash", bus.LED, 16'hFFFF);
        tick();
        chk("hit_pulse_end", bus.hit_pulse, 1'b0);
        chk("hit_led_flash2", bus.LED, 16'hFFFF);
        tick();
        chk("hit_to_gap_led", bus.LED, 16'h0);
        wait_show(4);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_led"}, bus.LED, 16'h0);
        chk({tag, "_score"}, bus.score_count, 8'h0);
        chk({tag, "_pulse"}, bus.hit_pulse, 1'b0);
        chk({tag, "_over"}, bus.game_over, 1'b0);
    endtask

    initial begin
        bus.sw = '0;
        bus.time_left = 8'd30;
        exp_prev = 4'hF;
        #3;
        check_reset_outputs("reset");

        @(negedge clk);
        reset = 1'b1;
        chk("idle_led", bus.LED, 16'h0);
        wait_show(5);

        do_hit(8'd0, 8'd1);

        // Miss: toggle a switch that is not the mole.
        bus.sw = bus.sw ^ onehot(exp_prev + 4'd1);
        tick();
        chk("miss_wait1_led", bus.LED, onehot(exp_prev));
        tick();
        chk("miss_wait2_led", bus.LED, onehot(exp_prev));
        tick();
        chk("miss_led", bus.LED, 16'h0);
        chk("miss_score", bus.score_count, 8'd1);
        chk("miss_pulse", bus.hit_pulse, 1'b0);
        wait_show(4);

        do_hit(8'd1, 8'd2);
        do_hit(8'd2, 8'd3);
        do_hit(8'd3, 8'd3);

        // Timeout with no toggle.
        for (int i = 0; i < 7; i++) tick();
        chk("timeout_last_led", bus.LED, onehot(exp_prev));
        tick();
        chk("timeout_led", bus.LED, 16'h0);
        chk("timeout_score", bus.score_count, 8'd3);
        wait_show(4);

        // Timer expiry on the same edge as a valid hit.
        bus.sw = bus.sw ^ onehot(exp_prev);
        tick();
        tick();
        bus.time_left = 8'd0;
        tick();
        chk("over_flag", bus.game_over, 1'b1);
        chk("over_led", bus.LED, 16'h0);
        chk("over_score", bus.score_count, 8'd3);
        chk("over_pulse", bus.hit_pulse, 1'b0);
        bus.time_left = 8'd30;
        for (int i = 0; i < 3; i++) tick();
        chk("over_stay_flag", bus.game_over, 1'b1);
        chk("over_stay_led", bus.LED, 16'h0);

        // Restart, then reset asynchronously in the middle of a mole.
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_prev = 4'hF;
        wait_show(5);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        reset = 1'b1;
        exp_prev = 4'hF;
        wait_show(5);

        // Long run of timed-out moles; consecutive indices must differ.
        for (int m = 0; m < 200; m++) begin
            prev_led = bus.LED;
            for (int i = 0; i < 8; i++) tick();
            chk("run_gap_led", bus.LED, 16'h0);
            wait_show(4);
            chk("no_repeat", (bus.LED !== prev_led), 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
